// File: rtl/register_arbiter_pkg.sv
// register_arbiter_pkg: shared types and constants for the register-file write-port arbiter
package register_arbiter_pkg;
    localparam int REG_FIFO_DEPTH = 4;
    localparam int REG_ENTRY_W    = 37;

    typedef struct packed {
        logic        wren;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } register_write_in_type;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } register_fifo_entry_type;

    typedef struct packed {
        logic        pipe_wren;
        logic [4:0]  pipe_waddr;
        logic [31:0] pipe_wdata;
        logic        lsu_valid;
        logic [4:0]  lsu_waddr;
        logic [31:0] lsu_wdata;
        logic        rsv_valid;
        logic [4:0]  rsv_addr;
        logic        chk_rden1;
        logic [4:0]  chk_raddr1;
        logic        chk_rden2;
        logic [4:0]  chk_raddr2;
        logic        chk_wren;
        logic [4:0]  chk_waddr;
    } register_arbiter_in_type;

    typedef struct packed {
        logic                  lsu_ready;
        logic                  chk_hazard;
        logic                  pipe_stall;
        register_write_in_type register_win;
    } register_arbiter_out_type;
endpackage

// File: rtl/register_arbiter_fifo.sv
// register_fifo: DEPTH x W synchronous FIFO for buffered long-latency writebacks
// Ports: push/push_data enqueue, pop dequeue, head is the oldest entry, full/empty status.
// The caller may push while full only when popping in the same cycle.
module register_fifo
    import register_arbiter_pkg::*;
#(
    parameter int DEPTH = REG_FIFO_DEPTH,
    parameter int W     = REG_ENTRY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/register_arbiter.sv
// register_arbiter: merges pipeline and long-latency writebacks onto one register-file write port
// Ports: pipe_* pipeline writeback (always wins unless x0), lsu_* buffered long-latency stream
// with lsu_ready, rsv_* destination reservation, chk_* hazard query -> chk_hazard,
// pipe_stall (registered anti-starvation pulse), register_win to the register file.
// Optional: define REGISTER_ARBITER_BYPASS_EN to let an LSU write skip the empty FIFO.
module register_arbiter
    import register_arbiter_pkg::*;
#(
    parameter int DEPTH      = REG_FIFO_DEPTH,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_wren,
    input  logic [4:0]            pipe_waddr,
    input  logic [31:0]           pipe_wdata,
    input  logic                  lsu_valid,
    input  logic [4:0]            lsu_waddr,
    input  logic [31:0]           lsu_wdata,
    output logic                  lsu_ready,
    input  logic                  rsv_valid,
    input  logic [4:0]            rsv_addr,
    input  logic                  chk_rden1,
    input  logic [4:0]            chk_raddr1,
    input  logic                  chk_rden2,
    input  logic [4:0]            chk_raddr2,
    input  logic                  chk_wren,
    input  logic [4:0]            chk_waddr,
    output logic                  chk_hazard,
    output logic                  pipe_stall,
    output register_write_in_type register_win
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    register_fifo_entry_type head;
    logic          full, empty, pipe_own, accept, bypass, push, commit;
    logic [31:0]   busy, clr_mask, set_mask;
    logic [CW-1:0] starve_cnt, starve_next;

    assign pipe_own  = pipe_wren && pipe_waddr != 5'd0;
    assign lsu_ready = !full;
    assign accept    = lsu_valid && lsu_ready;
`ifdef REGISTER_ARBITER_BYPASS_EN
    assign bypass = accept && lsu_waddr != 5'd0 && empty && !pipe_own;
`else
    assign bypass = 1'b0;
`endif
    // x0 writes are acknowledged but never stored
    assign push   = accept && lsu_waddr != 5'd0 && !bypass;
    assign commit = !empty && !pipe_own;

    register_fifo #(.DEPTH(DEPTH), .W(REG_ENTRY_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({lsu_waddr, lsu_wdata}),
        .pop       (commit),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        register_win = '0;
        if (pipe_own) register_win = '{1'b1, pipe_waddr, pipe_wdata};
        else if (bypass) register_win = '{1'b1, lsu_waddr, lsu_wdata};
        else if (!empty) register_win = '{1'b1, head.waddr, head.wdata};
    end

    // a bypassed write retires its destination exactly like a head commit
    assign clr_mask   = ({31'b0, commit} << head.waddr) | ({31'b0, bypass} << lsu_waddr);
    assign set_mask   = {31'b0, rsv_valid} << rsv_addr;
    assign chk_hazard = (chk_rden1 && busy[chk_raddr1]) || (chk_rden2 && busy[chk_raddr2])
                      || (chk_wren && busy[chk_waddr]);

    // counts consecutive cycles the waiting head is overridden; cleared after the stall pulse
    assign starve_next = (empty || !pipe_own || starve_cnt == CW'(STARVE_MAX)) ? '0
                                                                               : starve_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else begin
            busy       <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
            starve_cnt <= starve_next;
            pipe_stall <= starve_next == CW'(STARVE_MAX);
        end
    end
endmodule

// File: tb/tb_register_arbiter.sv
// tb_register_arbiter: directed and randomized self-checking bench for register_arbiter
module tb_register_arbiter;
    import register_arbiter_pkg::*;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;
`ifdef REGISTER_ARBITER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic pipe_wren, lsu_valid, lsu_ready, rsv_valid;
    logic chk_rden1, chk_rden2, chk_wren, chk_hazard, pipe_stall;
    logic [4:0] pipe_waddr, lsu_waddr, rsv_addr, chk_raddr1, chk_raddr2, chk_waddr;
    logic [31:0] pipe_wdata, lsu_wdata;
    register_write_in_type register_win;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    register_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wren(pipe_wren), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .lsu_valid(lsu_valid), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata), .lsu_ready(lsu_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .chk_rden1(chk_rden1), .chk_raddr1(chk_raddr1), .chk_rden2(chk_rden2),
        .chk_raddr2(chk_raddr2), .chk_wren(chk_wren), .chk_waddr(chk_waddr),
        .chk_hazard(chk_hazard), .pipe_stall(pipe_stall), .register_win(register_win)
    );

    // the pipeline must never write while pipe_stall is high
    always @(negedge clk)
        assert (!(rst_n && pipe_stall && pipe_wren))
        else begin
            fails++;
            $display("FAIL protocol: pipe_wren=1 while pipe_stall=1");
        end

    // address/data only matter when wren is set
    function automatic logic [37:0] view(input register_write_in_type w);
        return w.wren ? w : 38'd0;
    endfunction

    task automatic idle();
        pipe_wren = 0; pipe_waddr = 0; pipe_wdata = 0;
        lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
        rsv_valid = 0; rsv_addr = 0;
        chk_rden1 = 0; chk_raddr1 = 0; chk_rden2 = 0; chk_raddr2 = 0; chk_wren = 0; chk_waddr = 0;
    endtask

    task automatic reset_dut();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        chk_rden1 = 1; chk_raddr1 = 5'd1; chk_rden2 = 1; chk_raddr2 = 5'd17;
        chk_wren = 1; chk_waddr = 5'd31;
        #1;
        tests++; if (lsu_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", lsu_ready); end
        tests++; if (pipe_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", pipe_stall); end
        tests++; if (register_win.wren !== 1'b0) begin fails++; $display("FAIL reset_wren: got %b expected 0", register_win.wren); end
        tests++; if (chk_hazard !== 1'b0) begin fails++; $display("FAIL reset_hazard: got %b expected 0", chk_hazard); end
        next_cycle();
        idle();
    endtask

    task automatic test_hazard_commit();
        reset_dut();
        rsv_valid = 1; rsv_addr = 5'd5; chk_rden1 = 1; chk_raddr1 = 5'd5;
        #1;
        tests++; if (chk_hazard !== 1'b0) begin fails++; $display("FAIL haz_rsv_cycle: got %b expected 0", chk_hazard); end
        next_cycle();
        rsv_valid = 0; lsu_valid = 1; lsu_waddr = 5'd5; lsu_wdata = 32'hDEADBEEF;
        #1;
        tests++; if (chk_hazard !== 1'b1) begin fails++; $display("FAIL haz_rs1: got %b expected 1", chk_hazard); end
        tests++; if (lsu_ready !== 1'b1) begin fails++; $display("FAIL hc_ready: got %b expected 1", lsu_ready); end
        tests++; if (view(register_win) !== (BYP ? {1'b1, 5'd5, 32'hDEADBEEF} : 38'd0))
            begin fails++; $display("FAIL hc_accept_cycle: got %h expected %h", view(register_win), BYP ? {1'b1, 5'd5, 32'hDEADBEEF} : 38'd0); end
        chk_rden1 = 0; chk_rden2 = 1; chk_raddr2 = 5'd5;
        #1;
        tests++; if (chk_hazard !== 1'b1) begin fails++; $display("FAIL haz_rs2: got %b expected 1", chk_hazard); end
        chk_rden2 = 0; chk_wren = 1; chk_waddr = 5'd5;
        #1;
        tests++; if (chk_hazard !== 1'b1) begin fails++; $display("FAIL haz_rd: got %b expected 1", chk_hazard); end
        chk_waddr = 5'd6;
        #1;
        tests++; if (chk_hazard !== 1'b0) begin fails++; $display("FAIL haz_other: got %b expected 0", chk_hazard); end
        chk_waddr = 5'd5;
        next_cycle();
        lsu_valid = 0;
        #1;
        tests++; if (view(register_win) !== (BYP ? 38'd0 : {1'b1, 5'd5, 32'hDEADBEEF}))
            begin fails++; $display("FAIL hc_commit: got %h expected %h", view(register_win), BYP ? 38'd0 : {1'b1, 5'd5, 32'hDEADBEEF}); end
        tests++; if (chk_hazard !== !BYP) begin fails++; $display("FAIL haz_commit_cycle: got %b expected %b", chk_hazard, !BYP); end
        next_cycle();
        #1;
        tests++; if (chk_hazard !== 1'b0) begin fails++; $display("FAIL haz_cleared: got %b expected 0", chk_hazard); end
        tests++; if (register_win.wren !== 1'b0) begin fails++; $display("FAIL hc_idle: got %b expected 0", register_win.wren); end
        idle();
    endtask

    task automatic test_starvation();
        logic [37:0] exp_w;
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            pipe_wren = !pipe_stall; pipe_waddr = 5'd3; pipe_wdata = 32'(i);
            lsu_valid = (i == 0); lsu_waddr = 5'd7; lsu_wdata = 32'h1;
            #1;
            exp_w = (i == 9) ? {1'b1, 5'd7, 32'h1} : {1'b1, 5'd3, 32'(i)};
            tests++; if (pipe_stall !== (i == 9)) begin fails++; $display("FAIL starve_stall[%0d]: got %b expected %b", i, pipe_stall, i == 9); end
            tests++; if (view(register_win) !== exp_w) begin fails++; $display("FAIL starve_win[%0d]: got %h expected %h", i, view(register_win), exp_w); end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_fifo_full();
        logic [37:0] exp_w;
        logic exp_r;
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            pipe_wren = (i < 5) || (i == 6); pipe_waddr = 5'd3; pipe_wdata = 32'hC000_0000 + 32'(i);
            lsu_valid = i < 7;
            lsu_waddr = (i < 4) ? 5'(16 + i) : 5'd20;
            lsu_wdata = (i < 4) ? 32'(100 + i) : 32'd104;
            #1;
            exp_r = !(i == 4 || i == 5 || i == 7);
            exp_w = pipe_wren ? {1'b1, 5'd3, pipe_wdata}
                  : (i == 5) ? {1'b1, 5'd16, 32'd100}
                  : (i >= 7 && i <= 10) ? {1'b1, 5'(10 + i), 32'(94 + i)} : 38'd0;
            tests++; if (lsu_ready !== exp_r) begin fails++; $display("FAIL full_ready[%0d]: got %b expected %b", i, lsu_ready, exp_r); end
            tests++; if (view(register_win) !== exp_w) begin fails++; $display("FAIL full_win[%0d]: got %h expected %h", i, view(register_win), exp_w); end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_set_wins();
        reset_dut();
        rsv_valid = 1; rsv_addr = 5'd9;
        next_cycle();
        rsv_valid = 0; pipe_wren = 1; pipe_waddr = 5'd3; lsu_valid = 1; lsu_waddr = 5'd9; lsu_wdata = 32'h99;
        next_cycle();
        pipe_wren = 0; lsu_valid = 0; rsv_valid = 1; rsv_addr = 5'd9; chk_rden1 = 1; chk_raddr1 = 5'd9;
        #1;
        tests++; if (view(register_win) !== {1'b1, 5'd9, 32'h99}) begin fails++; $display("FAIL sw_commit: got %h expected %h", view(register_win), {1'b1, 5'd9, 32'h99}); end
        next_cycle();
        rsv_valid = 0;
        #1;
        tests++; if (chk_hazard !== 1'b1) begin fails++; $display("FAIL set_wins: got %b expected 1", chk_hazard); end
        pipe_wren = 1; lsu_valid = 1; lsu_wdata = 32'h98;
        next_cycle();
        pipe_wren = 0; lsu_valid = 0;
        #1;
        tests++; if (view(register_win) !== {1'b1, 5'd9, 32'h98}) begin fails++; $display("FAIL sw_commit2: got %h expected %h", view(register_win), {1'b1, 5'd9, 32'h98}); end
        next_cycle();
        #1;
        tests++; if (chk_hazard !== 1'b0) begin fails++; $display("FAIL sw_clear: got %b expected 0", chk_hazard); end
        idle();
    endtask

    task automatic test_x0();
        logic any;
        reset_dut();
        lsu_valid = 1; lsu_waddr = 5'd0; lsu_wdata = 32'h55; pipe_wren = 1; pipe_waddr = 5'd0; pipe_wdata = 32'h66;
        #1;
        tests++; if (register_win.wren !== 1'b0) begin fails++; $display("FAIL x0_wren: got %b expected 0", register_win.wren); end
        next_cycle();
        idle();
        #1;
        tests++; if (register_win.wren !== 1'b0) begin fails++; $display("FAIL x0_not_queued: got %b expected 0", register_win.wren); end
        any = 0;
        chk_rden1 = 1;
        for (int a = 0; a < 32; a++) begin
            chk_raddr1 = 5'(a);
            #0.1;
            any |= chk_hazard;
        end
        tests++; if (any !== 1'b0) begin fails++; $display("FAIL x0_busy: got %b expected 0", any); end
        next_cycle();
        chk_rden1 = 0; pipe_wren = 1; pipe_waddr = 5'd3; lsu_valid = 1; lsu_waddr = 5'd4; lsu_wdata = 32'h44;
        next_cycle();
        lsu_valid = 0; pipe_waddr = 5'd0;
        #1;
        tests++; if (view(register_win) !== {1'b1, 5'd4, 32'h44}) begin fails++; $display("FAIL x0_pipe_yields: got %h expected %h", view(register_win), {1'b1, 5'd4, 32'h44}); end
        next_cycle();
        idle();
        #1;
        tests++; if (register_win.wren !== 1'b0) begin fails++; $display("FAIL x0_drained: got %b expected 0", register_win.wren); end
    endtask

    task automatic test_bypass();
        reset_dut();
        lsu_valid = 1; lsu_waddr = 5'd12; lsu_wdata = 32'hA5A5;
        #1;
        tests++; if (view(register_win) !== (BYP ? {1'b1, 5'd12, 32'hA5A5} : 38'd0))
            begin fails++; $display("FAIL byp_same: got %h expected %h", view(register_win), BYP ? {1'b1, 5'd12, 32'hA5A5} : 38'd0); end
        next_cycle();
        lsu_valid = 0;
        #1;
        tests++; if (view(register_win) !== (BYP ? 38'd0 : {1'b1, 5'd12, 32'hA5A5}))
            begin fails++; $display("FAIL byp_next: got %h expected %h", view(register_win), BYP ? 38'd0 : {1'b1, 5'd12, 32'hA5A5}); end
        next_cycle();
        idle();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            pipe_wren = 1; pipe_waddr = 5'd3; lsu_valid = 1; lsu_waddr = 5'(1 + i); lsu_wdata = 32'(i);
            rsv_valid = 1; rsv_addr = 5'(1 + i);
            next_cycle();
        end
        idle();
        chk_rden1 = 1; chk_raddr1 = 5'd1;
        #1 rst_n = 0;
        #1;
        tests++; if (lsu_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: got %b expected 1", lsu_ready); end
        tests++; if (register_win.wren !== 1'b0) begin fails++; $display("FAIL mid_wren: got %b expected 0", register_win.wren); end
        tests++; if (chk_hazard !== 1'b0) begin fails++; $display("FAIL mid_hazard: got %b expected 0", chk_hazard); end
        next_cycle();
        rst_n = 1;
        #1;
        tests++; if (register_win.wren !== 1'b0) begin fails++; $display("FAIL mid_flushed: got %b expected 0", register_win.wren); end
        next_cycle();
        idle();
    endtask

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    task automatic test_random();
        ent_t q[$];
        bit [31:0] bm, clr;
        int lost;
        bit stall_m, pown, acc, byp, nonempty, exp_r, exp_h;
        logic [37:0] exp_w;
        reset_dut();
        bm = 0; lost = 0; stall_m = 0;
        for (int c = 0; c < 600; c++) begin
            pipe_wren = ($urandom_range(3) != 0) && !pipe_stall;
            pipe_waddr = 5'($urandom_range(7)); pipe_wdata = $urandom;
            lsu_valid = 1'($urandom_range(1)); lsu_waddr = 5'($urandom_range(7)); lsu_wdata = $urandom;
            rsv_addr = 5'($urandom_range(7, 1));
            rsv_valid = $urandom_range(1) == 1 && !bm[rsv_addr];
            chk_rden1 = 1'($urandom_range(1)); chk_raddr1 = 5'($urandom_range(7));
            chk_rden2 = 1'($urandom_range(1)); chk_raddr2 = 5'($urandom_range(7));
            chk_wren = 1'($urandom_range(1)); chk_waddr = 5'($urandom_range(7));
            #1;
            exp_r = q.size() < DEPTH;
            pown = pipe_wren && pipe_waddr != 0;
            acc = lsu_valid && exp_r;
            nonempty = q.size() != 0;
            byp = BYP && acc && lsu_waddr != 0 && !nonempty && !pown;
            if (pown) exp_w = {1'b1, pipe_waddr, pipe_wdata};
            else if (byp) exp_w = {1'b1, lsu_waddr, lsu_wdata};
            else if (nonempty) exp_w = {1'b1, q[0].a, q[0].d};
            else exp_w = 38'd0;
            exp_h = (chk_rden1 && bm[chk_raddr1]) || (chk_rden2 && bm[chk_raddr2]) || (chk_wren && bm[chk_waddr]);
            tests++; if (view(register_win) !== exp_w) begin fails++; $display("FAIL rnd_win[%0d]: got %h expected %h", c, view(register_win), exp_w); end
            tests++; if (lsu_ready !== exp_r) begin fails++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, lsu_ready, exp_r); end
            tests++; if (chk_hazard !== exp_h) begin fails++; $display("FAIL rnd_hazard[%0d]: got %b expected %b", c, chk_hazard, exp_h); end
            tests++; if (pipe_stall !== stall_m) begin fails++; $display("FAIL rnd_stall[%0d]: got %b expected %b", c, pipe_stall, stall_m); end
            clr = 0;
            if (!pown && nonempty) begin
                clr[q[0].a] = 1;
                void'(q.pop_front());
            end
            if (byp) clr[lsu_waddr] = 1;
            if (acc && lsu_waddr != 0 && !byp) q.push_back('{lsu_waddr, lsu_wdata});
            bm &= ~clr;
            if (rsv_valid) bm[rsv_addr] = 1;
            bm[0] = 0;
            if (nonempty && pown && lost < STARVE_MAX) lost++;
            else lost = 0;
            stall_m = lost == STARVE_MAX;
            next_cycle();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_hazard_commit();
        test_starvation();
        test_fifo_full();
        test_set_wins();
        test_x0();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
